exp_adc_cmd_sched: RTL and testbench



---
 rtl/exp_adc_pkg.sv | 15 +
 rtl/exp_adc_tick_gen.sv | 57 +++++
 rtl/exp_adc_cmd_sched.sv | 102 ++++++++++
 tb/tb_exp_adc_cmd_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_adc_pkg.sv
// rtl/exp_adc_pkg.sv - shared types and constants for the ADC command scheduler
package exp_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_t;

    localparam logic        TUSER_CONV  = 1'b1;
    localparam logic        TUSER_CFG   = 1'b0;
    localparam int          DIV_MIN     = 2;
    localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/exp_adc_tick_gen.sv
// rtl/exp_adc_tick_gen.sv - conversion period counter, pending flag and overrun counter
module exp_adc_tick_gen
    import exp_adc_pkg::*;
#(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 take,
    input  logic                 clear,
    output logic                 pending,
    output logic [15:0]          overrun_count
);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] last;
    logic                 tick;
    logic                 overrun;

    always_comb begin
        last = (divider < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN - 1)
                                                : divider - DIV_WIDTH'(1);
    end

    // >= lets a shrunk divider wrap immediately instead of running to overflow
    assign tick    = enable && (count >= last);
    // A tick coinciding with the scheduler consuming the pending flag is not lost
    assign overrun = tick && pending && !take;

    always_ff @(posedge aclk) begin
        if (areset) begin
            count         <= '0;
            pending       <= 1'b0;
            overrun_count <= '0;
        end else begin
            if (!enable || count >= last)
                count <= '0;
            else
                count <= count + DIV_WIDTH'(1);

            if (!enable)
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;
            else if (take)
                pending <= 1'b0;

            if (clear)
                overrun_count <= overrun ? 16'd1 : 16'd0;
            else if (overrun && overrun_count != OVERRUN_MAX)
                overrun_count <= overrun_count + 16'd1;
        end
    end

endmodule

// File: rtl/exp_adc_cmd_sched.sv
// rtl/exp_adc_cmd_sched.sv - arbitrates periodic conversions and software commands into the SPI engine
module exp_adc_cmd_sched
    import exp_adc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DIV_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  divider,
    input  logic [DATA_WIDTH-1:0] conv_cmd,
    input  logic [DATA_WIDTH-1:0] s_cfg_axis_tdata,
    input  logic                  s_cfg_axis_tvalid,
    output logic                  s_cfg_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  spi_done,
    input  logic                  clear_err,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [15:0]           overrun_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    sched_state_t   state;
    logic [TW-1:0]  tcnt;
    logic           pending;
    logic           take;
    logic           timeout_now;

    assign take              = (state == ST_IDLE) && pending;
    assign s_cfg_axis_tready = (state == ST_IDLE) && !pending;
    assign busy              = (state != ST_IDLE);
    assign timeout_now       = (state == ST_WAIT_DONE) && !spi_done
                               && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    exp_adc_tick_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick_gen (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .divider       (divider),
        .take          (take),
        .clear         (clear_err),
        .pending       (pending),
        .overrun_count (overrun_count)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= ST_IDLE;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            tcnt          <= '0;
            timeout_err   <= 1'b0;
        end else begin
            // A fresh timeout outranks a simultaneous clear
            if (timeout_now)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        m_axis_tdata  <= conv_cmd;
                        m_axis_tuser  <= TUSER_CONV;
                        m_axis_tvalid <= 1'b1;
                        state         <= ST_SEND;
                    end else if (s_cfg_axis_tvalid) begin
                        m_axis_tdata  <= s_cfg_axis_tdata;
                        m_axis_tuser  <= TUSER_CFG;
                        m_axis_tvalid <= 1'b1;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        tcnt          <= '0;
                        state         <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_done || timeout_now)
                        state <= ST_IDLE;
                    else
                        tcnt <= tcnt + TW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_adc_cmd_sched.sv
// tb/tb_exp_adc_cmd_sched.sv - directed self-checking bench for exp_adc_cmd_sched
module tb_exp_adc_cmd_sched;

    localparam int DW = 32;
    localparam int TO = 24;

    logic          aclk = 1'b0;
    logic          areset;
    logic          enable;
    logic [31:0]   divider;
    logic [DW-1:0] conv_cmd;
    logic [DW-1:0] s_cfg_axis_tdata;
    logic          s_cfg_axis_tvalid;
    logic          s_cfg_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          spi_done;
    logic          clear_err;
    logic          busy;
    logic          timeout_err;
    logic [15:0]   overrun_count;

    int n_checks = 0;
    int n_pass   = 0;

    bit resp_en    = 1'b0;
    int resp_delay = 3;
    int resp_cnt   = 0;

    exp_adc_cmd_sched #(
        .DATA_WIDTH     (DW),
        .DIV_WIDTH      (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .enable            (enable),
        .divider           (divider),
        .conv_cmd          (conv_cmd),
        .s_cfg_axis_tdata  (s_cfg_axis_tdata),
        .s_cfg_axis_tvalid (s_cfg_axis_tvalid),
        .s_cfg_axis_tready (s_cfg_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .spi_done          (spi_done),
        .clear_err         (clear_err),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .overrun_count     (overrun_count)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cyc();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // SPI engine model: pulses spi_done resp_delay cycles after each handshake
    initial begin
        spi_done = 1'b0;
        forever begin
            @(negedge aclk);
            #2;
            spi_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0)
                    spi_done = 1'b1;
            end
            if (resp_en && m_axis_tvalid && m_axis_tready)
                resp_cnt = resp_delay;
        end
    end

    initial begin
        int n;
        int pulses;
        int first;
        int prev;
        int extra;
        bit busy_ok;

        areset            = 1'b1;
        enable            = 1'b0;
        divider           = 32'd10;
        conv_cmd          = 32'hA5A5_0001;
        s_cfg_axis_tdata  = '0;
        s_cfg_axis_tvalid = 1'b0;
        m_axis_tready     = 1'b0;
        clear_err         = 1'b0;

        cyc();
        cyc();
        check_eq("rst_tvalid", m_axis_tvalid, 0);
        check_eq("rst_tdata", m_axis_tdata, 0);
        check_eq("rst_tuser", m_axis_tuser, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_overrun", overrun_count, 0);
        areset = 1'b0;
        cyc();
        check_eq("idle_cfg_tready", s_cfg_axis_tready, 1);

        // periodic conversions, divider 10
        m_axis_tready = 1'b1;
        resp_en       = 1'b1;
        resp_delay    = 3;
        enable        = 1'b1;
        pulses = 0; first = 0; prev = 0;
        for (int i = 1; i <= 35; i++) begin
            cyc();
            if (m_axis_tvalid) begin
                check_eq("conv_tuser", m_axis_tuser, 1);
                check_eq("conv_tdata", m_axis_tdata, 32'hA5A5_0001);
                if (pulses > 0)
                    check_eq("conv_period", i - prev, 10);
                else
                    first = i;
                prev = i;
                pulses++;
            end
        end
        check_eq("conv_pulses", pulses, 3);
        check_eq("conv_first_latency", first, 11);
        check_eq("conv_overrun", overrun_count, 0);
        enable = 1'b0;
        cyc(); cyc(); cyc();

        // two back-to-back software commands
        resp_delay        = 5;
        s_cfg_axis_tdata  = 32'h11;
        s_cfg_axis_tvalid = 1'b1;
        check_eq("sw1_cfg_tready", s_cfg_axis_tready, 1);
        cyc();
        check_eq("sw1_tvalid", m_axis_tvalid, 1);
        check_eq("sw1_tdata", m_axis_tdata, 32'h11);
        check_eq("sw1_tuser", m_axis_tuser, 0);
        check_eq("sw1_cfg_tready_low", s_cfg_axis_tready, 0);
        s_cfg_axis_tdata = 32'h22;
        n = 0; busy_ok = 1'b1;
        while (!s_cfg_axis_tready && n < 20) begin
            if (!busy) busy_ok = 1'b0;
            cyc();
            n++;
        end
        check_eq("sw2_tready_latency", n, 6);
        check_eq("sw1_busy", busy_ok, 1);
        cyc();
        s_cfg_axis_tvalid = 1'b0;
        check_eq("sw2_tvalid", m_axis_tvalid, 1);
        check_eq("sw2_tdata", m_axis_tdata, 32'h22);
        check_eq("sw2_tuser", m_axis_tuser, 0);
        n = 0;
        while (busy && n < 30) begin cyc(); n++; end
        check_eq("sw2_done_latency", n, 6);

        // divider 4 with a slow SPI transaction: overruns accumulate
        resp_delay = 16;
        divider    = 32'd4;
        enable     = 1'b1;
        n = 0;
        while (!m_axis_tvalid && n < 20) begin cyc(); n++; end
        check_eq("ovr_first_latency", n, 5);
        check_eq("ovr_first_tuser", m_axis_tuser, 1);
        cyc();
        n = 1;
        while (!m_axis_tvalid && n < 40) begin cyc(); n++; end
        check_eq("ovr_second_gap", n, 18);
        check_eq("ovr_second_tuser", m_axis_tuser, 1);
        check_eq("ovr_count", overrun_count, 3);
        check_eq("ovr_no_timeout", timeout_err, 0);
        enable = 1'b0;
        n = 0; extra = 0;
        while (busy && n < 40) begin
            cyc();
            n++;
            if (m_axis_tvalid) extra++;
        end
        check_eq("ovr_second_done", n, 17);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (m_axis_tvalid) extra++;
        end
        check_eq("ovr_no_extra_conv", extra, 0);
        check_eq("ovr_count_hold", overrun_count, 3);

        // missing spi_done: timeout
        resp_en           = 1'b0;
        s_cfg_axis_tdata  = 32'h33;
        s_cfg_axis_tvalid = 1'b1;
        cyc();
        s_cfg_axis_tvalid = 1'b0;
        check_eq("to_tvalid", m_axis_tvalid, 1);
        n = 0;
        while (!timeout_err && n < 60) begin cyc(); n++; end
        check_eq("to_latency", n, TO + 1);
        check_eq("to_idle", busy, 0);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        check_eq("clr_timeout_err", timeout_err, 0);
        check_eq("clr_overrun", overrun_count, 0);

        // conversion wins over a simultaneous software request
        resp_en    = 1'b1;
        resp_delay = 3;
        divider    = 32'd10;
        enable     = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check_eq("prio_cfg_tready", s_cfg_axis_tready, 0);
        check_eq("prio_idle", busy, 0);
        s_cfg_axis_tdata  = 32'h44;
        s_cfg_axis_tvalid = 1'b1;
        cyc();
        enable = 1'b0;
        check_eq("prio_conv_tvalid", m_axis_tvalid, 1);
        check_eq("prio_conv_tuser", m_axis_tuser, 1);
        check_eq("prio_conv_tdata", m_axis_tdata, 32'hA5A5_0001);
        check_eq("prio_cfg_blocked", s_cfg_axis_tready, 0);
        n = 0;
        while (!(m_axis_tvalid && !m_axis_tuser) && n < 20) begin cyc(); n++; end
        s_cfg_axis_tvalid = 1'b0;
        check_eq("prio_sw_latency", n, 5);
        check_eq("prio_sw_tdata", m_axis_tdata, 32'h44);
        n = 0;
        while (busy && n < 20) begin cyc(); n++; end
        check_eq("prio_sw_done", n, 4);

        // backpressure in SEND, then reset mid-SEND
        m_axis_tready     = 1'b0;
        s_cfg_axis_tdata  = 32'h55;
        s_cfg_axis_tvalid = 1'b1;
        cyc();
        s_cfg_axis_tvalid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_eq("bp_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {1'b1, 1'b0, 32'h55});
            cyc();
        end
        check_eq("bp_no_timeout", timeout_err, 0);
        check_eq("bp_busy", busy, 1);
        m_axis_tready = 1'b1;
        n = 0;
        while (busy && n < 20) begin cyc(); n++; end
        check_eq("bp_done", n, 4);

        s_cfg_axis_tdata  = 32'h66;
        s_cfg_axis_tvalid = 1'b1;
        m_axis_tready     = 1'b0;
        cyc();
        s_cfg_axis_tvalid = 1'b0;
        cyc();
        areset = 1'b1;
        cyc();
        check_eq("mrst_tvalid", m_axis_tvalid, 0);
        check_eq("mrst_tdata", m_axis_tdata, 0);
        check_eq("mrst_tuser", m_axis_tuser, 0);
        check_eq("mrst_busy", busy, 0);
        areset        = 1'b0;
        m_axis_tready = 1'b1;
        cyc();
        check_eq("mrst_cfg_tready", s_cfg_axis_tready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
